// File: rtl/strided_circular_buffer.sv
// -----------------------------------------------------------------------------
// strided_circular_buffer
//
// Circular row buffer between the input-feature fetch stage and the PE array.
// Each accepted write stores PAR_WRITE rows; the read side exposes a window of
// PAR_READ consecutive rows starting at the read pointer. A pop advances the
// read pointer by a variable stride (1..PAR_READ). Overlapping windows can
// therefore be re-read for sliding-window reuse.
//
// Optional feature macro: STRIDED_BUF_FLUSH_EN
//   defined     -> adds input 'flush'. It empties the buffer by moving rp to
//                  wp. A write in the same cycle is still kept. A pop in the
//                  same cycle is dropped.
//   not defined -> no flush port. The buffer empties only by reset or pops.
//
// Ports
//   clk         in   1                    single clock, all state on posedge
//   rst         in   1                    asynchronous, active-low reset
//   flush       in   1                    (STRIDED_BUF_FLUSH_EN only) logical flush
//   wr_valid    in   1                    producer offers din
//   wr_ready    out  1                    room for PAR_WRITE more rows
//   din         in   ROW_SIZE*PAR_WRITE   row 0 in the LSBs
//   rd_valid    out  1                    a full PAR_READ-row window is stored
//   rd_pop      in   1                    consume rd_advance rows
//   rd_advance  in   clog2(PAR_READ+1)    stride of this pop (clamped to PAR_READ)
//   dout        out  ROW_SIZE*PAR_READ    window; row at read pointer in the LSBs
//   level       out  clog2(COLUMNS+1)     rows currently stored
//   full        out  1                    level == COLUMNS
//   empty       out  1                    level == 0
// -----------------------------------------------------------------------------
module strided_circular_buffer #(
    parameter int ROW_SIZE  = 8,
    parameter int COLUMNS   = 32,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef STRIDED_BUF_FLUSH_EN
    input  logic                              flush,
`endif
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ROW_SIZE*PAR_WRITE-1:0]     din,
    output logic                              rd_valid,
    input  logic                              rd_pop,
    input  logic [$clog2(PAR_READ+1)-1:0]     rd_advance,
    output logic [ROW_SIZE*PAR_READ-1:0]      dout,
    output logic [$clog2(COLUMNS+1)-1:0]      level,
    output logic                              full,
    output logic                              empty
);

    localparam int AW    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int LW    = $clog2(COLUMNS + 1);
    localparam int ADV_W = $clog2(PAR_READ + 1);

    // Pointer sums are one bit wider than a pointer so the carry past
    // COLUMNS-1 is visible to the single conditional subtract.
    typedef logic [AW:0] sum_t;
    localparam sum_t COLS_S = sum_t'(COLUMNS);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    // (base + off) mod COLUMNS. Both operands are below COLUMNS, so one
    // conditional subtract is enough even when COLUMNS is not a power of two.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input sum_t off);
        sum_t s;
        s = {1'b0, base} + off;
        if (s >= COLS_S) s = s - COLS_S;
        return s[AW-1:0];
    endfunction

    // NOTE: storage has no reset. Stored rows are only visible through
    // level/rp, and those are reset. Leaving the array unreset lets it map
    // onto plain RAM or flops without a reset tree.
    logic [ROW_SIZE-1:0] mem [COLUMNS];

    logic [AW-1:0]    wp, rp;
    logic [AW-1:0]    wp_next, rp_next;
    logic [LW-1:0]    level_next;
    state_t           state, state_next;
    logic [ADV_W-1:0] adv_eff;
    logic             wr_fire, rd_fire, flush_req;

`ifdef STRIDED_BUF_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Handshakes use the registered level only. There is no same-cycle
    // bypass from write to read.
    assign wr_ready = (level <= LW'(COLUMNS - PAR_WRITE));
    assign rd_valid = (level >= LW'(PAR_READ));

    assign adv_eff  = (rd_advance > ADV_W'(PAR_READ)) ? ADV_W'(PAR_READ) : rd_advance;
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_pop & rd_valid & (adv_eff != '0);

    assign full     = (state == S_FULL);
    assign empty    = (state == S_EMPTY);

    // NOTE: every signal assigned in always_comb gets a default at the top.
    // A path that skips an assignment would otherwise infer a latch.
    always_comb begin
        wp_next    = wp;
        rp_next    = rp;
        level_next = level;

        if (wr_fire) wp_next = wrap_add(wp, sum_t'(PAR_WRITE));

        if (flush_req) begin
            // Flush keeps a same-cycle write: those rows start at the old wp,
            // which becomes the new read pointer. A same-cycle pop is dropped.
            rp_next    = wp;
            level_next = wr_fire ? LW'(PAR_WRITE) : '0;
        end else begin
            if (rd_fire) rp_next = wrap_add(rp, sum_t'(adv_eff));
            // Occupancy cannot leave 0..COLUMNS: writes need headroom and
            // pops need a full window. Modular arithmetic at LW bits is exact.
            level_next = level
                       + (wr_fire ? LW'(PAR_WRITE) : LW'(0))
                       - (rd_fire ? LW'(adv_eff)   : LW'(0));
        end
    end

    // The state follows the next occupancy. A flush that also accepts a write
    // lands in PARTIAL, so full/empty always agree with level.
    always_comb begin
        state_next = S_PARTIAL;
        if (level_next == '0)               state_next = S_EMPTY;
        else if (level_next == LW'(COLUMNS)) state_next = S_FULL;
    end

    // Pointers, occupancy and control state. Asynchronous clear.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            state <= S_EMPTY;
        end else begin
            wp    <= wp_next;
            rp    <= rp_next;
            level <= level_next;
            state <= state_next;
        end
    end

    // Row storage. Writes that straddle COLUMNS-1 -> 0 wrap row by row.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                mem[wrap_add(wp, sum_t'(i))] <= din[i*ROW_SIZE +: ROW_SIZE];
            end
        end
    end

    // Read window, combinational from storage. Forced to zero until a full
    // window exists, so stale rows never reach the PE array.
    always_comb begin
        dout = '0;
        if (rd_valid) begin
            for (int j = 0; j < PAR_READ; j++) begin
                dout[j*ROW_SIZE +: ROW_SIZE] = mem[wrap_add(rp, sum_t'(j))];
            end
        end
    end

endmodule
